switch_event_filter: RTL and testbench
======================================

SWITCH_EVENT_FILTER -- requirements
Module: switch_event_filter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning consecutive stable samples required to accept a level change (10 ms at 25 MHz).
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 25000000, meaning the number of cycles held after press_o before long_o fires.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 5000000, meaning the auto-repeat period after long_o.
REQ-004 SHALL have port clk_i  input  1  system clock; the block uses one clock and all logic is on its rising edge.
REQ-005 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sw_i  input  1  raw, asynchronous, bouncing switch input.
REQ-007 SHALL have port sw_o  output  1  debounced switch level.
REQ-008 SHALL have port press_o  output  1  one-cycle pulse on the debounced rising edge; this feeds the downstream digit counter.
REQ-009 SHALL have port release_o  output  1  one-cycle pulse on the debounced falling edge.
REQ-010 SHALL have port long_o  output  1  one-cycle pulse when the long-press threshold is reached.
REQ-011 SHALL have port repeat_o  output  1  one-cycle auto-repeat pulse.

Function
REQ-012 SHALL pass sw_i through a two-flop synchroniser before any other logic uses it.
REQ-013 SHALL increment the debounce counter each cycle the synchronised input differs from sw_o, and SHALL clear the counter on any cycle the two are equal (bounce).
REQ-014 SHALL toggle sw_o on the edge where the debounce counter reaches DEBOUNCE_CYCLES, then clear the counter; latency from a clean sw_i step to the sw_o change is 2+DEBOUNCE_CYCLES cycles.
REQ-015 SHALL assert press_o in the first cycle sw_o is 1, and release_o in the first cycle sw_o is 0; press_o and release_o are never asserted together.
REQ-016 SHALL implement FSM states IDLE, PRESSED and LONG_HELD: IDLE->PRESSED on press; PRESSED->LONG_HELD when the hold count reaches LONG_PRESS_CYCLES; PRESSED or LONG_HELD->IDLE on release.
REQ-017 SHALL start a hold counter at 0 in the press_o cycle and assert long_o for exactly one cycle, LONG_PRESS_CYCLES cycles after press_o.
REQ-018 SHALL, in LONG_HELD, assert repeat_o once every REPEAT_CYCLES cycles, with the first pulse REPEAT_CYCLES cycles after long_o.
REQ-019 SHALL give release priority when release coincides with a long_o or repeat_o threshold: release_o asserts, and long_o and repeat_o do not.
REQ-020 SHALL continue hold counting while a release debounce is in progress, because sw_o is still 1 during that time.
REQ-021 SHALL size each counter as $clog2(max+1) bits; counters saturate and never wrap.
REQ-022 SHALL flag an elaboration error if any parameter is below 1.

Reset
REQ-023 SHALL, on rst_n_i low, immediately force all of the following to 0: sw_o, press_o, release_o, long_o, repeat_o, the synchroniser flops and all counters; the FSM goes to IDLE.
REQ-024 SHALL, if a reset occurs mid-press, stay in IDLE after reset deassertion; a switch still held re-debounces and produces a fresh press_o after 2+DEBOUNCE_CYCLES cycles.

Configuration
REQ-025 SHALL, with macro SWITCH_AUTO_REPEAT_EN defined, generate repeat_o as in REQ-018.
REQ-026 SHALL, without SWITCH_AUTO_REPEAT_EN, tie repeat_o to 0 and omit the repeat counter; LONG_HELD is still entered and long_o still pulses.

Structure
REQ-027 SHALL take its FSM state enum and the default timing constants from shared package switch_pkg.
REQ-028 SHALL place the synchroniser, the debounce counter and the sw_o register in sub-module switch_debounce_core; the top level holds the edge detection, FSM and hold/repeat counters.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=5)
REQ-029 SHALL check: clean sw_i 0->1 step -> sw_o=1 and press_o=1 at cycle 6, press_o=0 at cycle 7.
REQ-030 SHALL check: sw_i toggled every 2 cycles for 30 cycles, then left at 0 -> no press_o, and sw_o stays 0.
REQ-031 SHALL check: sw_i held high for 60 cycles -> press_o at cycle 6, long_o at cycle 26, repeat_o at cycles 31, 36, 41, ... (with the macro), or repeat_o always 0 (without the macro).
REQ-032 SHALL check: sw_i driven low so that release debounce completes exactly at cycle 26 -> release_o=1 at cycle 26 and long_o never asserts.
REQ-033 SHALL check: rst_n_i pulsed low at cycle 15 of a hold, sw_i still high -> all outputs 0 immediately, then a new press_o 6 cycles after reset deasserts.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared definitions for the switch event filter: FSM state encoding and default timing.
package switch_pkg;

  localparam int DEF_DEBOUNCE_CYCLES   = 250000;
  localparam int DEF_LONG_PRESS_CYCLES = 25000000;
  localparam int DEF_REPEAT_CYCLES     = 5000000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } sw_state_e;

endpackage

// File: rtl/switch_debounce_core.sv
// Two-flop synchroniser plus stable-sample debounce counter that owns the debounced level.
module switch_debounce_core
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sw_i,
  output logic sw_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("switch_debounce_core: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [1:0]    sync_q, sync_d;
  logic          sw_q, sw_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], sw_i};
    sw_d   = sw_q;
    cnt_d  = '0;
    // Any sample equal to the current level is treated as bounce and restarts the count.
    if (sync_q[1] != sw_q) begin
      if (cnt_q >= CNT_LAST) begin
        sw_d  = ~sw_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      sw_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      sw_q   <= sw_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sw_o = sw_q;

endmodule

// File: rtl/switch_event_filter.sv
// Switch event filter: debounced level, press/release pulses, long-press and auto-repeat.
// Auto-repeat is generated only when the macro SWITCH_AUTO_REPEAT_EN is defined.
module switch_event_filter
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sw_i,
  output logic sw_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("switch_event_filter: all timing parameters must be at least 1");
  end

  switch_debounce_core #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_core (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .sw_i   (sw_i),
    .sw_o   (sw_o)
  );

  logic          sw_prev_q, sw_prev_d;
  sw_state_e     state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;

  assign press_o   = sw_o & ~sw_prev_q;
  assign release_o = ~sw_o & sw_prev_q;

  always_comb begin
    sw_prev_d = sw_o;
    state_d   = state_q;
    long_o    = 1'b0;
    // Hold count reads 0 in the press cycle, so it equals N exactly N cycles later.
    hold_d    = '0;
    if (state_q == IDLE) begin
      hold_d = press_o ? HW'(1) : '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + HW'(1);
    end else begin
      hold_d = hold_q;
    end

    case (state_q)
      IDLE: begin
        if (press_o) state_d = PRESSED;
      end
      PRESSED: begin
        // A release in the threshold cycle wins: sw_o is already 0 then.
        if (!sw_o) begin
          state_d = IDLE;
        end else if (hold_q == HOLD_MAX) begin
          long_o  = 1'b1;
          state_d = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (!sw_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sw_prev_q <= 1'b0;
      state_q   <= IDLE;
      hold_q    <= '0;
    end else begin
      sw_prev_q <= sw_prev_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
    end
  end

`ifdef SWITCH_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES);

  logic [RW-1:0] rep_q, rep_d;

  // Phase counter reads 0 in the long_o cycle and reloads to 1 after each pulse.
  always_comb begin
    rep_d    = '0;
    repeat_o = 1'b0;
    if (long_o) begin
      rep_d = RW'(1);
    end else if (state_q == LONG_HELD && sw_o) begin
      if (rep_q == REP_MAX) begin
        repeat_o = 1'b1;
        rep_d    = RW'(1);
      end else begin
        rep_d = rep_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_switch_event_filter.sv
// Directed bench for switch_event_filter with a cycle-level event model and literal event-time checks.
module tb_switch_event_filter;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw = 1'b0;
  logic sw_o, press, rel, lng, rpt;

  switch_event_filter #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L),
    .REPEAT_CYCLES    (R)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .sw_i     (sw),
    .sw_o     (sw_o),
    .press_o  (press),
    .release_o(rel),
    .long_o   (lng),
    .repeat_o (rpt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int base = 0;

  int press_log[$];
  int rel_log[$];
  int long_log[$];
  int rep_log[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  always @(posedge clk) cyc++;

  // Model: the level flips once D consecutive raw samples (seen through the
  // 2-cycle synchroniser) disagree with it; events follow from time since press.
  int  raw_q[$];
  bit  m_sw = 1'b0;
  bit  m_prev = 1'b0;
  int  since = -1;

  always @(posedge clk or negedge rst_n) begin : model
    bit all_diff;
    int s;
    if (!rst_n) begin
      raw_q.delete();
      m_sw   = 1'b0;
      m_prev = 1'b0;
      since  = -1;
    end else begin
      raw_q.push_back(int'(sw));
      m_prev = m_sw;
      s = raw_q.size();
      if (s >= D + 2) begin
        all_diff = 1'b1;
        for (int k = s - 2 - D; k <= s - 3; k++)
          if (raw_q[k] == int'(m_sw)) all_diff = 1'b0;
        if (all_diff) m_sw = !m_sw;
      end
      if (m_sw && !m_prev) since = 0;
      else if (m_sw) since++;
      else since = -1;
    end
  end

  always @(negedge clk) begin : compare
    bit e_rep;
`ifdef SWITCH_AUTO_REPEAT_EN
    e_rep = m_sw && since > L && ((since - L) % R) == 0;
`else
    e_rep = 1'b0;
`endif
    chk("m_sw_o",    int'(sw_o),  int'(m_sw));
    chk("m_press",   int'(press), int'(m_sw && !m_prev));
    chk("m_release", int'(rel),   int'(!m_sw && m_prev));
    chk("m_long",    int'(lng),   int'(m_sw && since == L));
    chk("m_repeat",  int'(rpt),   int'(e_rep));
    if (press) press_log.push_back(cyc);
    if (rel)   rel_log.push_back(cyc);
    if (lng)   long_log.push_back(cyc);
    if (rpt)   rep_log.push_back(cyc);
  end

  task automatic start_scenario();
    @(negedge clk);
    base = cyc;
    press_log.delete();
    rel_log.delete();
    long_log.delete();
    rep_log.delete();
  endtask

  task automatic wait_rel(input int k);
    while (cyc - base < k) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sw_o"},    int'(sw_o),  0);
    chk({tag, "_press"},   int'(press), 0);
    chk({tag, "_release"}, int'(rel),   0);
    chk({tag, "_long"},    int'(lng),   0);
    chk({tag, "_repeat"},  int'(rpt),   0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero(tag);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic int first_of(input int q[$], input int b);
    return (q.size() > 0) ? q[0] - b : -1;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("rst_init");
    #2 rst_n = 1'b1;

    // Clean press held 60 cycles, then released.
    start_scenario();
    sw = 1'b1;
    wait_rel(5);
    chk("hold_sw_o_c5", int'(sw_o), 0);
    wait_rel(6);
    chk("hold_sw_o_c6", int'(sw_o), 1);
    chk("hold_press_c6", int'(press), 1);
    wait_rel(7);
    chk("hold_press_c7", int'(press), 0);
    wait_rel(60);
    sw = 1'b0;
    wait_rel(72);
    chk("hold_press_n", press_log.size(), 1);
    chk("hold_press_at", first_of(press_log, base), 6);
    chk("hold_long_n", long_log.size(), 1);
    chk("hold_long_at", first_of(long_log, base), 26);
    chk("hold_rel_n", rel_log.size(), 1);
    chk("hold_rel_at", first_of(rel_log, base), 66);
`ifdef SWITCH_AUTO_REPEAT_EN
    chk("hold_rep_n", rep_log.size(), 7);
    chk("hold_rep_at0", first_of(rep_log, base), 31);
    if (rep_log.size() >= 7) begin
      chk("hold_rep_at1", rep_log[1] - base, 36);
      chk("hold_rep_at2", rep_log[2] - base, 41);
      chk("hold_rep_last", rep_log[6] - base, 61);
    end
`else
    chk("hold_rep_n", rep_log.size(), 0);
`endif
    do_reset("rst_a");

    // Bounce: toggle every 2 cycles for 30 cycles, then low.
    start_scenario();
    for (int i = 0; i < 30; i++) begin
      sw = ((i / 2) % 2) == 0;
      @(negedge clk);
    end
    sw = 1'b0;
    repeat (12) @(negedge clk);
    chk("bounce_press_n", press_log.size(), 0);
    chk("bounce_rel_n", rel_log.size(), 0);
    chk("bounce_sw_o", int'(sw_o), 0);
    do_reset("rst_b");

    // Release debounce completes exactly at the long-press threshold.
    start_scenario();
    sw = 1'b1;
    wait_rel(20);
    sw = 1'b0;
    wait_rel(32);
    chk("tie_press_at", first_of(press_log, base), 6);
    chk("tie_rel_n", rel_log.size(), 1);
    chk("tie_rel_at", first_of(rel_log, base), 26);
    chk("tie_long_n", long_log.size(), 0);
    chk("tie_rep_n", rep_log.size(), 0);
    do_reset("rst_c");

    // Reset in the middle of a hold with the switch still pressed.
    start_scenario();
    sw = 1'b1;
    wait_rel(15);
    chk("mid_sw_o_before", int'(sw_o), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_rst");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    base = cyc;
    press_log.delete();
    long_log.delete();
    wait_rel(10);
    chk("mid_press_n", press_log.size(), 1);
    chk("mid_press_at", first_of(press_log, base), 6);
    chk("mid_long_n", long_log.size(), 0);
    sw = 1'b0;
    wait_rel(20);
    chk("mid_sw_o_end", int'(sw_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
